// File: rtl/counter_binary_bounded.sv
// Bounded binary up/down counter with programmable limits,
// wrap or saturate behaviour, chaining carry and event pulses.
module counter_binary_bounded #(
    parameter int                    WORD_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0] INITIAL_COUNT = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  up_down,
    input  logic [WORD_WIDTH-1:0] increment,
    input  logic [WORD_WIDTH-1:0] limit_low,
    input  logic [WORD_WIDTH-1:0] limit_high,
    input  logic                  saturate,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_count,
    output logic [WORD_WIDTH-1:0] count,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  range_error
);

    localparam int W1 = WORD_WIDTH + 1;

    logic [WORD_WIDTH-1:0] r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_range_error;

    // One extra bit so a full-range span of 2^WORD_WIDTH is representable
    logic [W1-1:0] w_count_x;
    logic [W1-1:0] w_inc_x;
    logic [W1-1:0] w_low_x;
    logic [W1-1:0] w_high_x;
    logic [W1-1:0] w_span;
    logic [W1-1:0] w_sum;
    logic [W1-1:0] w_diff;
    logic          w_cfg_err;
    logic          w_out_of_range;
    logic          w_cross_up;
    logic          w_cross_dn;
    logic [WORD_WIDTH-1:0] w_wrap_up;
    logic [WORD_WIDTH-1:0] w_wrap_dn;
    logic [WORD_WIDTH-1:0] w_next;
    logic                  w_ovf;
    logic                  w_udf;
    logic                  w_rerr;

    assign w_count_x = {1'b0, r_count};
    assign w_inc_x   = {1'b0, increment};
    assign w_low_x   = {1'b0, limit_low};
    assign w_high_x  = {1'b0, limit_high};
    assign w_span    = w_high_x - w_low_x + W1'(1);
    assign w_sum     = w_count_x + w_inc_x;
    assign w_diff    = w_count_x - w_inc_x;

    assign w_cfg_err      = limit_low > limit_high;
    assign w_out_of_range = (r_count < limit_low) || (r_count > limit_high);

    // Difference is treated as signed so a step below zero still compares low
    assign w_cross_up = w_sum > w_high_x;
    assign w_cross_dn = $signed(w_diff) < $signed(w_low_x);

    assign w_wrap_up = WORD_WIDTH'(w_sum - w_span);
    assign w_wrap_dn = WORD_WIDTH'(w_diff + w_span);

    // Next count and event flags for a step, assuming run is the winner
    always_comb begin
        w_next = r_count;
        w_ovf  = 1'b0;
        w_udf  = 1'b0;
        w_rerr = 1'b0;
        if (w_cfg_err) begin
            w_rerr = 1'b1;
        end else if (w_out_of_range) begin
            w_rerr = 1'b1;
            w_next = up_down ? limit_high : limit_low;
        end else if (!up_down) begin
            if (w_cross_up) begin
                w_ovf  = 1'b1;
                w_next = saturate ? limit_high : w_wrap_up;
            end else begin
                w_next = WORD_WIDTH'(w_sum);
            end
        end else begin
            if (w_cross_dn) begin
                w_udf  = 1'b1;
                w_next = saturate ? limit_low : w_wrap_dn;
            end else begin
                w_next = WORD_WIDTH'(w_diff);
            end
        end
    end

    assign carry_out = run & ~load & ~clear & (w_ovf | w_udf);

    // Count register and single-cycle event pulses: clear > load > run > hold
    always_ff @(posedge clock) begin
        if (clear) begin
            r_count       <= INITIAL_COUNT;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_range_error <= 1'b0;
        end else if (load) begin
            r_count       <= load_count;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_range_error <= 1'b0;
        end else if (run) begin
            r_count       <= w_next;
            r_overflow    <= w_ovf;
            r_underflow   <= w_udf;
            r_range_error <= w_rerr;
        end else begin
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_range_error <= 1'b0;
        end
    end

    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign range_error = r_range_error;

endmodule

// File: doc/counter_binary_bounded.md
# counter_binary_bounded

Parametrised successor to the plain binary up/down counter. It adds runtime increment, programmable lower/upper count limits, a per-cycle selectable wrap or saturate mode, and a combinational carry for chaining. It also adds registered overflow, underflow and range-error event pulses. It sits wherever a datapath needs a bounded counter: ring-buffer pointers, byte counters with multi-byte steps, and timers that clamp.

## Interface
- WORD_WIDTH, 8: width of count, limits, increment; must be ≥ 1.
- INITIAL_COUNT, 0: value of `count` after reset; WORD_WIDTH bits.

- clock  in  1  sole clock; all state changes on rising edge.
- clear  in  1  reset, synchronous, active-high; also usable during operation.
- run  in  1  perform one step this cycle.
- up_down  in  1  0 = count up, 1 = count down.
- increment  in  WORD_WIDTH  step size, unsigned.
- limit_low  in  WORD_WIDTH  lowest legal count, unsigned.
- limit_high  in  WORD_WIDTH  highest legal count, unsigned.
- saturate  in  1  0 = wrap within the limits, 1 = clamp at the limits.
- load  in  1  load `load_count` this cycle.
- load_count  in  WORD_WIDTH  value to load; any value is accepted.
- count  out  WORD_WIDTH  current count, registered.
- carry_out  out  1  combinational; high when `run` is high and this step crosses a limit in either direction.
- overflow  out  1  registered one-cycle pulse: the last step crossed `limit_high`.
- underflow  out  1  registered one-cycle pulse: the last step crossed `limit_low`.
- range_error  out  1  registered one-cycle pulse: the last step was attempted with bad limits or an out-of-range count.

## Operation
- Priority: clear > load > run > hold.
- clear: `count` = INITIAL_COUNT; overflow, underflow and range_error = 0.
- load: `count` = load_count, with no range check. Flags are 0 in the cycle following a load.
- Arithmetic: all sums, differences and span use WORD_WIDTH+1 bits.
  - span = limit_high − limit_low + 1.
  - A full-range span of 2^WORD_WIDTH must work.
- Up step, sum = count + increment:
  - sum ≤ limit_high: next = sum.
  - Otherwise, with crossing: wrap gives next = sum − span; saturate gives next = limit_high. overflow is pulsed.
- Down step, diff = count − increment (signed, WORD_WIDTH+1 bits):
  - diff ≥ limit_low: next = diff.
  - Otherwise, with crossing: wrap gives next = diff + span; saturate gives next = limit_low. underflow is pulsed.
- Saturate mode flags every clamped step, including a repeated push against a limit that is already reached.
- Configuration error (limit_low > limit_high) with run: `count` holds and range_error is pulsed.
- Out-of-range count (count < limit_low or count > limit_high) with run and valid limits:
  - next = limit_low when counting up, limit_high when counting down.
  - range_error is pulsed; overflow and underflow stay 0.
- increment > span in wrap mode is a configuration error. The count stays a WORD_WIDTH value; its exact value is unspecified, but overflow/underflow still pulse.
- increment = 0: count holds, no flags.
- carry_out = run & !load & !clear & (crossing up or down). It is 0 on configuration or range error. It is intended for ANDing into the `run` of the next chained counter.

## Timing
- Reset values: count = INITIAL_COUNT, overflow = underflow = range_error = 0.
- Latency: count and flags update on the edge that samples run, load or clear. A flag is high for exactly the cycle in which the new count is visible.
- carry_out is valid in the same cycle as its inputs, before the edge.
- Limits, increment, saturate and up_down are sampled only in cycles where run is high. Changing them between steps is legal and takes effect on the next step.
- clear mid-operation overrides everything in the same cycle and cancels any flag that would have pulsed.
- No multi-cycle state: each step is a single cycle, and a step can be issued every cycle.

## Test plan
WORD_WIDTH=8 throughout.
- Wrap up: low=3, high=9, inc=2, saturate=0, load 3, run 4 cycles -> count 5,7,9,4. overflow pulses only with 4; carry_out is high in the cycle before.
- Saturate down: low=3, high=9, inc=4, saturate=1, load 9, run 3 cycles -> count 5,3,3. underflow pulses with each 3.
- Full range: low=0, high=255, inc=1, wrap. Load 255 and run up -> 0 with overflow. Then run down -> 255 with underflow.
- Priority: clear+load+run together -> INITIAL_COUNT, no flags. Then load_count=42 with load+run -> 42, no flags.
- Range handling: low=3, high=9, load 20, run up -> count 3 and range_error. Then set low=10, high=5, run -> count holds 3 and range_error.
- Reset mid-operation: clear asserted in the same cycle as an overflowing run -> count = INITIAL_COUNT, overflow stays 0.
